// File: rtl/seg7_scan_mux.sv
// Time-multiplexed driver for common-anode 7-segment digits on a shared segment bus.
// A shadow register holds the displayed data; outputs are registered one clk behind the scan index.
module seg7_scan_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   num,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    input  logic                      lzb_en,
    output logic [6:0]                seg7,
    output logic                      dpt,
    output logic [NUM_DIGITS-1:0]     digit_sel,
    output logic                      frame_tick
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0]           presc_q;
    logic [IW-1:0]           idx_q;
    logic [BW-1:0]           bcnt_q;
    logic                    phase_q;
    logic                    ftick_q;
    logic [4*NUM_DIGITS-1:0] num_q;
    logic [NUM_DIGITS-1:0]   dp_q;
    logic [NUM_DIGITS-1:0]   den_q;
    logic [NUM_DIGITS-1:0]   bm_q;
    logic [6:0]              seg_q, seg_d;
    logic                    dpt_q, dpt_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;

    logic                    adv;
    logic                    last;
    logic                    wrap;
    logic [3:0]              nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   lzb_blank;
    logic                    zero_run;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    assign adv  = en && (presc_q == PW'(SCAN_DIV - 1));
    assign last = (idx_q == IW'(NUM_DIGITS - 1));
    assign wrap = adv && last;

    // Leading-zero run scanned from the most significant digit down; any lit dp,
    // disabled digit or non-zero nibble ends the run. Digit 0 always shows.
    always_comb begin
        zero_run  = 1'b1;
        lzb_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nib[i]   = num_q[4*i +: 4];
            zero_run = zero_run && (nib[i] == 4'h0) && den_q[i] && !dp_q[i];
            lzb_blank[i] = lzb_en && zero_run && (i != 0);
        end
    end

    always_comb begin
        seg_d = 7'h7F;
        dpt_d = 1'b1;
        sel_d = '1;
        if (en) begin
            sel_d[idx_q] = 1'b0;
            if (den_q[idx_q] && !(bm_q[idx_q] && phase_q)) begin
                dpt_d = ~dp_q[idx_q];
                if (!lzb_blank[idx_q]) begin
                    seg_d = hex_to_seg(nib[idx_q]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
            ftick_q <= 1'b0;
            num_q   <= '0;
            dp_q    <= '0;
            den_q   <= '0;
            bm_q    <= '0;
            seg_q   <= 7'h7F;
            dpt_q   <= 1'b1;
            sel_q   <= '1;
        end else begin
            if (load) begin
                num_q <= num;
                dp_q  <= dp_in;
                den_q <= digit_en;
                bm_q  <= blink_mask;
            end
            if (en) begin
                presc_q <= adv ? '0 : presc_q + PW'(1);
                if (adv) begin
                    idx_q <= last ? '0 : idx_q + IW'(1);
                end
            end
            ftick_q <= wrap;
            // Blink phase advances on the same edge that raises frame_tick.
            if (wrap) begin
                if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
                    bcnt_q  <= '0;
                    phase_q <= ~phase_q;
                end else begin
                    bcnt_q <= bcnt_q + BW'(1);
                end
            end
            seg_q <= seg_d;
            dpt_q <= dpt_d;
            sel_q <= sel_d;
        end
    end

    assign seg7       = seg_q;
    assign dpt        = dpt_q;
    assign digit_sel  = sel_q;
    assign frame_tick = ftick_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: the reference model derives scan position and blink phase
// arithmetically from the number of enabled clock edges since reset.
module tb_seg7_scan_mux;

    localparam int N  = 4;
    localparam int SD = 4;
    localparam int BF = 2;
    localparam int FR = SD * N;
    localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   num = '0;
    logic [3:0]    dp_in = '0;
    logic [3:0]    digit_en = '0;
    logic [3:0]    blink_mask = '0;
    logic          lzb_en = 1'b0;
    logic [6:0]    seg7;
    logic          dpt;
    logic [3:0]    digit_sel;
    logic          frame_tick;

    int            vectors = 0;
    int            miscompares = 0;

    int            tcnt;
    logic [15:0]   m_num;
    logic [3:0]    m_dp, m_den, m_bm;
    logic [6:0]    exp_seg;
    logic          exp_dpt;
    logic [3:0]    exp_sel;
    logic          exp_ft;

    seg7_scan_mux #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .num(num), .dp_in(dp_in),
        .digit_en(digit_en), .blink_mask(blink_mask), .lzb_en(lzb_en),
        .seg7(seg7), .dpt(dpt), .digit_sel(digit_sel), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    function automatic bit lz_blank(input int i);
        if (!lzb_en || i == 0) return 1'b0;
        for (int j = i; j < N; j++) begin
            if (m_num[j*4 +: 4] != 4'h0 || !m_den[j] || m_dp[j]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        tcnt  = 0;
        m_num = '0;
        m_dp  = '0;
        m_den = '0;
        m_bm  = '0;
    endtask

    // Predict the post-edge outputs from pre-edge state, clock once, update the model.
    task automatic step();
        int idx, ph;
        logic [6:0] s;
        logic d;
        logic [3:0] sel;
        s   = 7'h7F;
        d   = 1'b1;
        sel = 4'hF;
        if (en) begin
            idx = (tcnt / SD) % N;
            ph  = ((tcnt / FR) / BF) % 2;
            sel[idx] = 1'b0;
            if (m_den[idx] && !(m_bm[idx] && ph == 1)) begin
                d = ~m_dp[idx];
                if (!lz_blank(idx)) s = HEX[m_num[idx*4 +: 4]];
            end
        end
        @(posedge clk);
        if (load) begin
            m_num = num;
            m_dp  = dp_in;
            m_den = digit_en;
            m_bm  = blink_mask;
        end
        if (en) tcnt++;
        exp_ft  = en && (tcnt % FR == 0) && tcnt > 0;
        exp_seg = s;
        exp_dpt = d;
        exp_sel = sel;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if ({seg7, dpt, digit_sel, frame_tick} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
                miscompares++;
                $display("FAIL reset: seg7=%h dpt=%b sel=%h ft=%b, want 7f 1 f 0", seg7, dpt, digit_sel, frame_tick);
            end
        end
        rst_n = 1'b1;
        en    = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_scan();
        num = 16'h12AF; digit_en = 4'hF; dp_in = 4'h0; blink_mask = 4'h0; lzb_en = 1'b0;
        load = 1'b1; en = 1'b1;
        for (int k = 0; k < 2 * FR + 1; k++) begin
            step();
            load = 1'b0;
            vectors++;
            if ({seg7, dpt, digit_sel, frame_tick} !== {exp_seg, exp_dpt, exp_sel, exp_ft}) begin
                miscompares++;
                $display("FAIL scan k=%0d: got %h %b %h %b, want %h %b %h %b", k,
                         seg7, dpt, digit_sel, frame_tick, exp_seg, exp_dpt, exp_sel, exp_ft);
            end
        end
    endtask

    task automatic test_lzb();
        for (int pass = 0; pass < 3; pass++) begin
            num    = (pass == 2) ? 16'h0000 : 16'h0050;
            dp_in  = (pass == 2) ? 4'b0100 : 4'b0000;
            lzb_en = (pass != 1);
            load   = 1'b1;
            for (int k = 0; k < FR + SD; k++) begin
                step();
                load = 1'b0;
                vectors++;
                if ({seg7, dpt, digit_sel, frame_tick} !== {exp_seg, exp_dpt, exp_sel, exp_ft}) begin
                    miscompares++;
                    $display("FAIL lzb pass=%0d k=%0d: got %h %b %h %b, want %h %b %h %b", pass, k,
                             seg7, dpt, digit_sel, frame_tick, exp_seg, exp_dpt, exp_sel, exp_ft);
                end
            end
        end
    endtask

    task automatic test_blink();
        int ticks;
        num = 16'($urandom); dp_in = 4'($urandom); digit_en = 4'hF; blink_mask = 4'b0001;
        lzb_en = 1'b0; load = 1'b1;
        ticks = 0;
        for (int k = 0; k < 8 * FR; k++) begin
            step();
            load = 1'b0;
            ticks += int'(frame_tick);
            vectors++;
            if ({seg7, dpt, digit_sel, frame_tick} !== {exp_seg, exp_dpt, exp_sel, exp_ft}) begin
                miscompares++;
                $display("FAIL blink k=%0d: got %h %b %h %b, want %h %b %h %b", k,
                         seg7, dpt, digit_sel, frame_tick, exp_seg, exp_dpt, exp_sel, exp_ft);
            end
        end
        vectors++;
        if (ticks != 8) begin
            miscompares++;
            $display("FAIL blink_ticks: got %0d frame_tick pulses, want 8", ticks);
        end
    endtask

    task automatic test_enable();
        int guard;
        guard = 0;
        while (!(((tcnt / SD) % N) == 2 && (tcnt % SD) == 1) && guard < 2 * FR) begin
            step();
            guard++;
        end
        vectors++;
        if (guard >= 2 * FR) begin
            miscompares++;
            $display("FAIL enable_reach: index 2 not reached in %0d cycles", guard);
        end
        for (int k = 0; k < 2 * FR + 6; k++) begin
            en = (k >= 6);
            step();
            vectors++;
            if ({seg7, dpt, digit_sel, frame_tick} !== {exp_seg, exp_dpt, exp_sel, exp_ft}) begin
                miscompares++;
                $display("FAIL enable k=%0d: got %h %b %h %b, want %h %b %h %b", k,
                         seg7, dpt, digit_sel, frame_tick, exp_seg, exp_dpt, exp_sel, exp_ft);
            end
        end
    endtask

    task automatic test_load_advance_reset();
        int guard;
        en = 1'b1;
        guard = 0;
        while ((tcnt % SD) != SD - 1 && guard < SD + 1) begin
            step();
            guard++;
        end
        num = 16'($urandom); dp_in = 4'($urandom); digit_en = 4'($urandom) | 4'h1;
        blink_mask = 4'h0; load = 1'b1;
        for (int k = 0; k < SD + 2; k++) begin
            step();
            load = 1'b0;
            vectors++;
            if ({seg7, dpt, digit_sel, frame_tick} !== {exp_seg, exp_dpt, exp_sel, exp_ft}) begin
                miscompares++;
                $display("FAIL load_adv k=%0d: got %h %b %h %b, want %h %b %h %b", k,
                         seg7, dpt, digit_sel, frame_tick, exp_seg, exp_dpt, exp_sel, exp_ft);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({seg7, dpt, digit_sel, frame_tick} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset: got %h %b %h %b, want 7f 1 f 0", seg7, dpt, digit_sel, frame_tick);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        model_reset();
        num = 16'h0000; dp_in = 4'h0; digit_en = 4'hF; lzb_en = 1'b1; load = 1'b1;
        for (int k = 0; k < FR + 2; k++) begin
            step();
            load = 1'b0;
            vectors++;
            if ({seg7, dpt, digit_sel, frame_tick} !== {exp_seg, exp_dpt, exp_sel, exp_ft}) begin
                miscompares++;
                $display("FAIL post_reset k=%0d: got %h %b %h %b, want %h %b %h %b", k,
                         seg7, dpt, digit_sel, frame_tick, exp_seg, exp_dpt, exp_sel, exp_ft);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            en   = ($urandom_range(0, 9) != 0);
            load = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) lzb_en = 1'($urandom);
            if (load) begin
                num        = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
                dp_in      = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
                digit_en   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
                blink_mask = 4'($urandom);
            end
            step();
            vectors++;
            if ({seg7, dpt, digit_sel, frame_tick} !== {exp_seg, exp_dpt, exp_sel, exp_ft}) begin
                miscompares++;
                $display("FAIL random k=%0d: got %h %b %h %b, want %h %b %h %b", k,
                         seg7, dpt, digit_sel, frame_tick, exp_seg, exp_dpt, exp_sel, exp_ft);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_lzb();
        test_blink();
        test_enable();
        test_load_advance_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
- Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits sharing one segment bus.
- Latches a packed hex word, decimal points and per-digit enables into a shadow register on `load`.
- Scans the digits at a prescaled rate and drives active-low segments and active-low one-hot digit selects.
- Adds leading-zero blanking and per-digit blink; sits between keypad/calculator datapath and board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8).
- SCAN_DIV, 50000, clk cycles per digit slot (>=2).
- BLINK_FRAMES, 32, full scan frames per blink half-period (>=1).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  scan enable; 0 = display dark, counters frozen.
- load  input  1  capture num/dp_in/digit_en/blink_mask into the shadow register.
- num  input  4*NUM_DIGITS  hex nibbles; nibble i = num[4i+3:4i], digit 0 = rightmost.
- dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit.
- digit_en  input  NUM_DIGITS  per-digit display enable, 0 = digit blank (segments and dp).
- blink_mask  input  NUM_DIGITS  1 = digit blanks during the blink-off phase.
- lzb_en  input  1  leading-zero blanking enable (live, not shadowed).
- seg7  output  7  segments gfedcba, active low.
- dpt  output  1  decimal point, active low.
- digit_sel  output  NUM_DIGITS  digit drive, active low, at most one bit low.
- frame_tick  output  1  one-cycle pulse when the scan index wraps to 0.

Behaviour:
- Reset (async, rst_n=0):
  - seg7=7'h7F, dpt=1, digit_sel all 1, frame_tick=0.
  - Prescaler=0, scan index=0, blink counter=0, blink_phase=0.
  - Shadow registers all 0.
- Shadow: on a clk edge with load=1, the shadow takes num/dp_in/digit_en/blink_mask regardless of en.
  - The new values affect outputs starting the cycle after capture.
- Prescaler:
  - With en=1, counts 0..SCAN_DIV-1 and wraps.
  - At count SCAN_DIV-1, the scan index advances (NUM_DIGITS-1 wraps to 0).
- frame_tick: asserted for exactly the cycle in which the index register holds 0 after a wrap. It is not asserted after reset.
- Blink:
  - The blink counter counts frame_ticks 0..BLINK_FRAMES-1.
  - At the terminal count, blink_phase toggles and the counter returns to 0.
  - blink_phase=1 is the off phase.
- Output pipeline:
  - seg7/dpt/digit_sel are registered, decoded from the current index and shadow.
  - Outputs lag the index by exactly one clk.
  - digit_sel = all 1 except bit index = 0.
- Per-digit decode priority, for digit i:
  - (a) shadow digit_en[i]=0, or blink_mask[i]=1 with blink_phase=1 → seg7=7F, dpt=1.
  - (b) LZB-blanked → seg7=7F, dpt from dp.
  - (c) otherwise hex decode and dpt=~dp[i].
- Hex table (seg7 hex, for values 0..F): 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
- LZB (lzb_en=1):
  - Digit i is blanked if every digit j>=i has nibble 0, digit_en[j]=1 and dp[j]=0.
  - Digit 0 is never LZB-blanked, so value 0 shows as a single "0".
  - A lit dp stops blanking at and below that digit.
- en=0:
  - Next edge gives digit_sel all 1, seg7=7F, dpt=1.
  - Prescaler, index and blink state hold their values; frame_tick=0.
  - en returning to 1 resumes from the held index.
- Simultaneous events:
  - load and an index advance on the same edge: both take effect; the output for the new index uses the new shadow on the following edge.
  - frame_tick and the blink terminal count on the same edge: phase toggles on that edge.
- Reset mid-scan: immediate dark display; scan restarts at index 0 with an empty shadow.

Test Plan:
- Reset, then load num=16'h12AF, digit_en=F, dp=0, en=1, SCAN_DIV=4 → digit_sel cycles E,D,B,7 every 4 clks with seg7 0E,08,24,79. No digit is low during reset.
- num=16'h0050, lzb_en=1 → digits 3 and 2 seg7=7F; digit 1=12; digit 0=40. With lzb_en=0, digit 3 = digit 2 = 40.
- num=0, dp_in=4'b0100, lzb_en=1 → digit 3 blank, digit 2 shows 40 with dpt=0, digits 1 and 0 show 40.
- blink_mask=4'b0001, BLINK_FRAMES=2 → digit 0 shows for 2 frames, then 7F/dpt=1 for 2 frames, and repeats. frame_tick is a single pulse per frame.
- en low mid-frame at index 2 → next edge all digit_sel=1. Raising en resumes at index 2 with the prescaler value preserved.
- load on the same edge as an index advance, then rst_n pulsed low asynchronously mid-cycle → new value appears one clk later. On reset: outputs 7F/1/all-1 immediately, index 0.
